// File: rtl/ring_counter_gen_if.sv
// Control/status bundle for ring_counter_gen.
// The master side drives step/load/mode controls; the slave side is the counter.
interface ring_counter_gen_if #(
  parameter int WIDTH = 4
);
  localparam int STEP_W = $clog2(2 * WIDTH);

  logic              en;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              mode;
  logic              dir;
  logic [WIDTH-1:0]  q;
  logic [STEP_W-1:0] step;
  logic              wrap;
  logic              err;

  modport master (
    output en, load, load_val, mode, dir,
    input  q, step, wrap, err
  );

  modport slave (
    input  en, load, load_val, mode, dir,
    output q, step, wrap, err
  );
endinterface

// File: rtl/ring_counter_gen.sv
// Parametrised ring / Johnson counter with run-time mode and direction,
// clock enable, parallel load and a period tracker that pulses wrap.
// Optional feature macro: RING_COUNTER_SELF_CORRECT_EN - when defined, a
// non-one-hot state in ring mode is replaced by RESET_PATTERN on the next
// enabled shift and err pulses for one cycle; when undefined err is 0.
module ring_counter_gen #(
  parameter int               WIDTH         = 4,
  parameter logic [WIDTH-1:0] RESET_PATTERN = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input logic             clk,
  input logic             reset,
  ring_counter_gen_if.slave bus
);
  localparam int             STEP_W    = $clog2(2 * WIDTH);
  localparam logic [STEP_W-1:0] LAST_RING = STEP_W'(WIDTH - 1);
  localparam logic [STEP_W-1:0] LAST_JOHN = STEP_W'(2 * WIDTH - 1);

  logic [WIDTH-1:0]  q_reg,    q_next;
  logic [STEP_W-1:0] step_reg, step_next;
  logic              wrap_reg, wrap_next;
  logic              mode_q_reg;

  logic [WIDTH-1:0]  shifted;
  logic              fb_left;
  logic              fb_right;
  logic              mode_change;
  logic [STEP_W-1:0] last_step;

  // Next shift value; the incoming mode is used so a mode switch applies on its own edge
  always_comb begin
    fb_left  = bus.mode ? ~q_reg[WIDTH-1] : q_reg[WIDTH-1];
    fb_right = bus.mode ? ~q_reg[0]       : q_reg[0];
    shifted  = bus.dir ? {fb_right, q_reg[WIDTH-1:1]}
                       : {q_reg[WIDTH-2:0], fb_left};
  end

`ifdef RING_COUNTER_SELF_CORRECT_EN
  logic err_reg, err_next;
  logic q_onehot;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
  always_comb begin
    q_onehot = (q_reg != '0) && ((q_reg & (q_reg - WIDTH'(1))) == '0);
  end
`endif

  // Next-state: load beats shift; step restarts on load, mode change or period end
  always_comb begin
    q_next      = q_reg;
    step_next   = step_reg;
    wrap_next   = 1'b0;
    mode_change = (bus.mode != mode_q_reg);
    last_step   = bus.mode ? LAST_JOHN : LAST_RING;
`ifdef RING_COUNTER_SELF_CORRECT_EN
    err_next    = 1'b0;
`endif
    if (bus.load) begin
      q_next    = bus.load_val;
      step_next = '0;
    end else if (bus.en) begin
      q_next = shifted;
      if (mode_change) begin
        step_next = '0;
      end else if (step_reg == last_step) begin
        step_next = '0;
        wrap_next = 1'b1;
      end else begin
        step_next = step_reg + STEP_W'(1);
      end
`ifdef RING_COUNTER_SELF_CORRECT_EN
      // Ring mode only: an illegal pattern is replaced rather than rotated
      if (!bus.mode && !q_onehot) begin
        q_next    = RESET_PATTERN;
        step_next = '0;
        wrap_next = 1'b0;
        err_next  = 1'b1;
      end
`endif
    end else if (mode_change) begin
      step_next = '0;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg      <= RESET_PATTERN;
      step_reg   <= '0;
      wrap_reg   <= 1'b0;
      mode_q_reg <= bus.mode;
    end else begin
      q_reg      <= q_next;
      step_reg   <= step_next;
      wrap_reg   <= wrap_next;
      mode_q_reg <= bus.mode;
    end
  end

`ifdef RING_COUNTER_SELF_CORRECT_EN
  // Correction pulse register
  always_ff @(posedge clk) begin
    if (reset) err_reg <= 1'b0;
    else       err_reg <= err_next;
  end
  assign bus.err = err_reg;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.q    = q_reg;
  assign bus.step = step_reg;
  assign bus.wrap = wrap_reg;
endmodule

// File: tb/tb_ring_counter_gen.sv
// Table-driven bench for ring_counter_gen at WIDTH=4, plus a free-running
// wrap-cadence sequence. Expected values are hand-derived.
module tb_ring_counter_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ring_counter_gen_if #(.WIDTH(4)) bus ();

  ring_counter_gen #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

`ifdef RING_COUNTER_SELF_CORRECT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  typedef struct packed {
    logic       rst, ld, en, md, dr;
    logic [3:0] lv;
    logic [3:0] q;
    logic [2:0] st;
    logic       wr, er;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic rst, ld, en, md, dr, input logic [3:0] lv,
                     input logic [3:0] q, input int st, input logic wr, er);
    vec_t v;
    v.rst = rst; v.ld = ld; v.en = en; v.md = md; v.dr = dr; v.lv = lv;
    v.q = q; v.st = 3'(st); v.wr = wr; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] eq, input logic [2:0] es,
                       input logic ew, input logic ee);
    checks++;
    if (bus.q !== eq || bus.step !== es || bus.wrap !== ew || bus.err !== ee) begin
      errors++;
      $display("FAIL %s: got q=%b step=%0d wrap=%b err=%b, need q=%b step=%0d wrap=%b err=%b",
               name, bus.q, bus.step, bus.wrap, bus.err, eq, es, ew, ee);
    end else begin
      $display("ok   %s: q=%b step=%0d wrap=%b err=%b", name, bus.q, bus.step, bus.wrap, bus.err);
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.mode = 1'b0; bus.dir = 1'b0;

    //   rst ld en md dr lv       q        st wr er
    // Reset, then ring left for 8 shifts
    add(1, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, 4'b0010, 1, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, 4'b0100, 2, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, 4'b1000, 3, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, 4'b0001, 0, 1, 0);
    add(0, 0, 1, 0, 0, 4'b0000, 4'b0010, 1, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, 4'b0100, 2, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, 4'b1000, 3, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, 4'b0001, 0, 1, 0);
    // Enable gating: wrap must drop while en is low, q holds
    add(0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
    add(0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, 4'b0010, 1, 0, 0);
    // Load beats en in the same cycle
    add(0, 1, 1, 0, 0, 4'b0100, 4'b0100, 0, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, 4'b1000, 1, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, 4'b0001, 2, 0, 0);
    // Mode switch to Johnson mid-period with en=1
    add(0, 0, 1, 1, 0, 4'b0000, 4'b0011, 0, 0, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b0111, 1, 0, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b1111, 2, 0, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b1110, 3, 0, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b1100, 4, 0, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b1000, 5, 0, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b0000, 6, 0, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b0001, 7, 0, 0);
    add(0, 0, 1, 1, 0, 4'b0000, 4'b0011, 0, 1, 0);
    // Johnson right from 0000
    add(0, 1, 0, 1, 1, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 0, 1, 1, 1, 4'b0000, 4'b1000, 1, 0, 0);
    add(0, 0, 1, 1, 1, 4'b0000, 4'b1100, 2, 0, 0);
    add(0, 0, 1, 1, 1, 4'b0000, 4'b1110, 3, 0, 0);
    add(0, 0, 1, 1, 1, 4'b0000, 4'b1111, 4, 0, 0);
    add(0, 0, 1, 1, 1, 4'b0000, 4'b0111, 5, 0, 0);
    add(0, 0, 1, 1, 1, 4'b0000, 4'b0011, 6, 0, 0);
    add(0, 0, 1, 1, 1, 4'b0000, 4'b0001, 7, 0, 0);
    add(0, 0, 1, 1, 1, 4'b0000, 4'b0000, 0, 1, 0);
    add(0, 0, 0, 1, 1, 4'b0000, 4'b0000, 0, 0, 0);
    // Mode change with en low clears step, q holds
    add(0, 0, 1, 1, 1, 4'b0000, 4'b1000, 1, 0, 0);
    add(0, 0, 0, 0, 1, 4'b0000, 4'b1000, 0, 0, 0);
    // Direction changes keep counting toward the same wrap
    add(0, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0);
    add(0, 0, 1, 0, 1, 4'b0000, 4'b1000, 2, 0, 0);
    add(0, 0, 1, 0, 1, 4'b0000, 4'b0100, 3, 0, 0);
    add(0, 0, 1, 0, 1, 4'b0000, 4'b0010, 0, 1, 0);
    // Reset at step 3 with en high discards the pending wrap
    add(0, 0, 1, 0, 0, 4'b0000, 4'b0100, 1, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, 4'b1000, 2, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, 4'b0001, 3, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
    // Illegal ring pattern: corrected only when the feature is built in
    add(0, 1, 0, 0, 0, 4'b0110, 4'b0110, 0, 0, 0);
    add(0, 0, 1, 0, 0, 4'b0000, SC ? 4'b0001 : 4'b1100, SC ? 0 : 1, 0, SC);
    add(0, 0, 0, 0, 0, 4'b0000, SC ? 4'b0001 : 4'b1100, SC ? 0 : 1, 0, 0);

    foreach (vecs[i]) begin
      reset        = vecs[i].rst;
      bus.load     = vecs[i].ld;
      bus.en       = vecs[i].en;
      bus.mode     = vecs[i].md;
      bus.dir      = vecs[i].dr;
      bus.load_val = vecs[i].lv;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].q, vecs[i].st, vecs[i].wr, vecs[i].er);
    end

    // Free-running ring left: wrap every 4th cycle, never stretched
    reset = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.mode = 1'b0; bus.dir = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; bus.en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      logic [3:0] eq;
      eq = 4'b0001 << (k % 4);
      @(posedge clk); #1;
      check($sformatf("run%0d", k), eq, 3'(k % 4), (k % 4) == 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
